// File: rtl/pslip_pkg.sv
// Shared types and defaults for the pSLIP scheduler blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pslip_pkg;

    localparam int N_DEF = 16;
    localparam int P_DEF = 64;
    localparam int C_DEF = $clog2(P_DEF);

    typedef logic [C_DEF-1:0] pri_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        ARB   = 3'd2,
        GRANT = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/pri_max_scan.sv
// MSB-first bit-serial max-priority candidate mask engine.
// Latency: one priority bit per step; C steps leave cand = all max-priority requesters.
// Backpressure: none; load/step are strobes from the owning FSM.
module pri_max_scan
    import pslip_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [N-1:0][C-1:0] pri_in,
    output logic [N-1:0]        cand
);

    // Captured priorities, shifted left each step so bit C-1 is always the bit under test.
    logic [N-1:0][C-1:0] pri_sh;
    logic [N-1:0]        msb;
    logic [N-1:0]        req_nz;
    logic [N-1:0]        hit;

    // Current bit-plane, nonzero-request mask on load, and surviving candidates.
    always_comb begin
        msb    = '0;
        req_nz = '0;
        for (int i = 0; i < N; i++) begin
            msb[i]    = pri_sh[i][C-1];
            req_nz[i] = |pri_in[i];
        end
        hit = cand & msb;
    end

    // Narrow the candidate set only when some candidate has the bit set; otherwise keep it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pri_sh <= '0;
            cand   <= '0;
        end else if (load) begin
            pri_sh <= pri_in;
            cand   <= req_nz;
        end else if (step) begin
            for (int i = 0; i < N; i++) begin
                pri_sh[i] <= pri_sh[i] << 1;
            end
            if (hit != '0) begin
                cand <= hit;
            end
        end
    end

endmodule

// File: rtl/pslip_out_grant_ctrl.sv
// Per-output-port pSLIP grant scheduler: max-priority scan, round-robin pick, grant hold.
// Latency: start at edge t -> gnt_valid from t+C+2, done earliest t+C+3 (t+1 when no requests).
// Backpressure: grant held until accept_valid; start ignored while busy; abort returns to IDLE.
module pslip_out_grant_ctrl
    import pslip_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int P  = P_DEF,
    localparam int C  = $clog2(P),
    localparam int PW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N-1:0][C-1:0] req_pri,
    input  logic                iter_first,
    input  logic                accept_valid,
    input  logic                accept,
    input  logic                abort,
    output logic [N-1:0]        gnt,
    output logic                gnt_valid,
    output logic                busy,
    output logic                done,
    output logic [PW-1:0]       ptr
);

    state_t         state;
    state_t         state_nxt;
    logic [C-1:0]   cnt;
    logic           scan_last;
    logic           req_any;
    logic           scan_load;
    logic           scan_step;
    logic [N-1:0]   cand;
    logic           pick_found;
    logic [PW-1:0]  pick_idx;
    logic [PW-1:0]  gnt_idx;
    logic           ptr_upd;

    pri_max_scan #(
        .N (N),
        .C (C)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .load   (scan_load),
        .step   (scan_step),
        .pri_in (req_pri),
        .cand   (cand)
    );

    assign scan_last = (cnt == C'(C - 1));

    // Any input requesting at all decides between scanning and an empty round.
    always_comb begin
        req_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_any = req_any | (|req_pri[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort takes priority over everything outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = req_any ? SCAN : DONE;
            SCAN:    if (abort) state_nxt = IDLE;
                     else if (scan_last) state_nxt = ARB;
            ARB:     state_nxt = abort ? IDLE : GRANT;
            GRANT:   if (abort) state_nxt = IDLE;
                     else if (accept_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs and scan-engine strobes.
    always_comb begin
        busy      = (state != IDLE);
        gnt_valid = (state == GRANT);
        done      = (state == DONE);
        scan_load = (state == IDLE) && start;
        scan_step = (state == SCAN);
    end

    // Scan step counter: counts bit-planes while in SCAN, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == SCAN) begin
            cnt <= cnt + C'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Round-robin pick: lowest candidate at or above ptr, else lowest candidate overall (wrap).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!pick_found && cand[i] && (i >= int'(ptr))) begin
                pick_found = 1'b1;
                pick_idx   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!pick_found && cand[i]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(i);
            end
        end
    end

    // Grant register: loaded leaving ARB, held through GRANT, cleared on any other exit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt     <= '0;
            gnt_idx <= '0;
        end else if ((state == ARB) && (state_nxt == GRANT)) begin
            gnt     <= N'(1) << pick_idx;
            gnt_idx <= pick_idx;
        end else if (state_nxt != GRANT) begin
            gnt <= '0;
        end
    end

    // Pointer advances past the granted input only on a first-iteration accept (iSLIP rule).
    assign ptr_upd = (state == GRANT) && accept_valid && !abort && accept && iter_first;

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (ptr_upd) begin
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

endmodule

// File: tb/tb_pslip_out_grant_ctrl.sv
module tb_pslip_out_grant_ctrl;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int C  = 3;
    localparam int PW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [N-1:0][C-1:0] req_pri;
    logic                iter_first;
    logic                accept_valid;
    logic                accept;
    logic                abort;
    logic [N-1:0]        gnt;
    logic                gnt_valid;
    logic                busy;
    logic                done;
    logic [PW-1:0]       ptr;

    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           mdl_ptr = 0;
    logic [N-1:0] exp_q[$];

    pslip_out_grant_ctrl #(
        .N (N),
        .P (P)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .req_pri      (req_pri),
        .iter_first   (iter_first),
        .accept_valid (accept_valid),
        .accept       (accept),
        .abort        (abort),
        .gnt          (gnt),
        .gnt_valid    (gnt_valid),
        .busy         (busy),
        .done         (done),
        .ptr          (ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pick: highest priority value, first such index at or after ptr, wrapping.
    function automatic int model_pick(input int p[4], input int rr);
        int mx;
        int idx;
        mx = 0;
        for (int i = 0; i < N; i++) if (p[i] > mx) mx = p[i];
        if (mx == 0) return -1;
        for (int i = 0; i < N; i++) begin
            idx = (rr + i) % N;
            if (p[idx] == mx) return idx;
        end
        return -1;
    endfunction

    task automatic set_pri(input int p[4]);
        for (int i = 0; i < N; i++) req_pri[i] = p[i][C-1:0];
    endtask

    // mode 0: normal; 1: abort together with accept_valid in GRANT;
    // 2: spurious start (other priorities) and accept_valid during SCAN.
    task automatic run_round(input int p0, input int p1, input int p2, input int p3,
                             input bit itf, input bit acc, input int hold, input int mode);
        int           p[4];
        int           pick;
        logic [N-1:0] oh;
        logic [N-1:0] exp_g;
        int           alt[4];
        p    = '{p0, p1, p2, p3};
        pick = model_pick(p, mdl_ptr);
        set_pri(p);
        iter_first = itf;
        if (pick >= 0) begin
            oh = '0;
            oh[pick] = 1'b1;
            exp_q.push_back(oh);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (pick < 0) begin
            chk("empty_done_t1", done, 1);
            chk("empty_gnt_valid", gnt_valid, 0);
            chk("empty_gnt", gnt, 0);
            tick();
            chk("empty_done_pulse_end", done, 0);
            chk("empty_idle", busy, 0);
            chk("empty_ptr", ptr, mdl_ptr);
            return;
        end
        for (int k = 0; k <= C; k++) begin
            chk("gnt_valid_low_pipe", gnt_valid, 0);
            chk("done_low_pipe", done, 0);
            if (mode == 2 && k == 0) begin
                alt = '{p3, p2, p1, p0};
                set_pri(alt);
                start = 1'b1;
            end
            if (mode == 2 && k == 1) begin
                accept_valid = 1'b1;
                accept       = 1'b1;
            end
            tick();
            start        = 1'b0;
            accept_valid = 1'b0;
            accept       = 1'b0;
        end
        chk("gnt_valid_at_tC2", gnt_valid, 1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            exp_g = '0;
        end else begin
            exp_g = exp_q.pop_front();
        end
        chk("gnt", gnt, exp_g);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("gnt_hold", gnt, exp_g);
            chk("gnt_valid_hold", gnt_valid, 1);
        end
        accept_valid = 1'b1;
        accept       = acc;
        abort        = (mode == 1);
        tick();
        accept_valid = 1'b0;
        accept       = 1'b0;
        abort        = 1'b0;
        if (mode == 1) begin
            chk("abort_idle", busy, 0);
            chk("abort_no_done", done, 0);
            chk("abort_gnt_valid", gnt_valid, 0);
            chk("abort_gnt", gnt, 0);
            chk("abort_ptr", ptr, mdl_ptr);
            return;
        end
        if (acc && itf) mdl_ptr = (pick + 1) % N;
        chk("done_pulse", done, 1);
        chk("done_gnt_valid", gnt_valid, 0);
        chk("done_gnt", gnt, 0);
        chk("ptr", ptr, mdl_ptr);
        tick();
        chk("done_pulse_end", done, 0);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        int pr[4];
        reset        = 1'b0;
        start        = 1'b0;
        req_pri      = '0;
        iter_first   = 1'b0;
        accept_valid = 1'b0;
        accept       = 1'b0;
        abort        = 1'b0;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ptr", ptr, 0);
        reset = 1'b1;
        tick();

        // Max-priority pick with round-robin advance and wrap.
        run_round(3, 5, 5, 1, 1'b1, 1'b1, 0, 0);
        run_round(3, 5, 5, 1, 1'b1, 1'b1, 2, 0);
        run_round(3, 5, 5, 1, 1'b1, 1'b1, 0, 0);

        // No requests: immediate done, pointer untouched.
        run_round(0, 0, 0, 0, 1'b1, 1'b1, 0, 0);

        // Abort wins over accept_valid in GRANT.
        run_round(7, 7, 7, 7, 1'b1, 1'b1, 1, 1);

        // Start and accept_valid during SCAN are ignored.
        run_round(0, 0, 0, 6, 1'b1, 1'b1, 0, 2);

        // Reset mid-SCAN discards the round.
        pr = '{2, 4, 0, 0};
        set_pri(pr);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mdl_ptr = 0;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_gnt_valid", gnt_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ptr", ptr, 0);
        tick();
        chk("midrst_no_done_after", done, 0);

        // Non-first iteration accept and first-iteration reject both leave ptr alone.
        run_round(0, 0, 7, 7, 1'b0, 1'b1, 0, 0);
        run_round(0, 0, 7, 7, 1'b1, 1'b0, 1, 0);

        // Full ties at top priority degrade to round-robin.
        run_round(7, 7, 7, 7, 1'b1, 1'b1, 0, 0);
        run_round(7, 7, 7, 7, 1'b1, 1'b1, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
